// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int REG_W_DEF    = 5;
    localparam int ZERO_REG_IDX = 31;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of the ID instruction.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int ZERO_REG = ZERO_REG_IDX
) (
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    output logic             hz
);

    logic rn_match;
    logic rm_match;

    assign rn_match = (ex_rd == id_rn);
    assign rm_match = id_uses_rm && (ex_rd == id_rm);

    // The zero register is never a real producer, so a load targeting it cannot stall.
    assign hz = ex_memread && (ex_rd != REG_W'(ZERO_REG)) && (rn_match || rm_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch flushes, multicycle handshake
// with timeout, and a saturating stall-cycle counter.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W      = REG_W_DEF,
    parameter int ZERO_REG   = ZERO_REG_IDX,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic             id_multi,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             br_taken,
    input  logic             mc_done,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             mc_start,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TMO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    state_t           state_reg;
    state_t           state_next;
    logic [TMO_W-1:0] tmo_reg;
    logic [TMO_W-1:0] tmo_next;
    logic             mc_err_reg;
    logic             err_set;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             hz;
    logic             tmo_last;

    hazard_detect #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
    ) u_hazard (
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_uses_rm (id_uses_rm),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .hz         (hz)
    );

    assign tmo_last = (tmo_reg == TMO_W'(MC_TIMEOUT - 1));

    // Outputs are Mealy and forced low while reset is held, independent of the clock.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        mc_start    = 1'b0;
        err_set     = 1'b0;
        state_next  = state_reg;
        tmo_next    = tmo_reg;
        if (reset) begin
            case (state_reg)
                RUN: begin
                    if (br_taken) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (hz) begin
                        idex_en     = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (id_multi) begin
                        mc_start    = 1'b1;
                        idex_en     = 1'b1;
                        idex_bubble = 1'b1;
                        tmo_next    = '0;
                        state_next  = MC_WAIT;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                        idex_en = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (mc_done || tmo_last) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        err_set    = !mc_done;
                        state_next = RUN;
                    end else begin
                        tmo_next = tmo_reg + TMO_W'(1);
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= RUN;
            tmo_reg       <= '0;
            mc_err_reg    <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            tmo_reg   <= tmo_next;
            if (err_set) begin
                mc_err_reg <= 1'b1;
            end
            if (!pc_en && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign mc_err    = mc_err_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized scoreboard bench for pipe_stall_ctrl against a behavioural model.
module tb_pipe_stall_ctrl;

    localparam int TO    = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             pc;
        logic             ifid;
        logic             idex;
        logic             bub;
        logic             flush;
        logic             start;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [4:0]       id_rn = '0, id_rm = '0, ex_rd = '0;
    logic             id_uses_rm = 1'b0, id_multi = 1'b0, ex_memread = 1'b0;
    logic             br_taken = 1'b0, mc_done = 1'b0;
    logic             pc_en, ifid_en, idex_en, idex_bubble, ifid_flush, mc_start, mc_err;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stall_ctrl #(
        .REG_W      (5),
        .ZERO_REG   (31),
        .MC_TIMEOUT (TO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_uses_rm  (id_uses_rm),
        .id_multi    (id_multi),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .br_taken    (br_taken),
        .mc_done     (mc_done),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .idex_bubble (idex_bubble),
        .ifid_flush  (ifid_flush),
        .mc_start    (mc_start),
        .mc_err      (mc_err),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Model state: whether a multicycle op is outstanding and how long it has waited.
    bit m_wait = 0;
    int m_wc   = 0;
    bit m_err  = 0;
    int m_cnt  = 0;

    task automatic step(input logic r, input logic [4:0] rn, input logic [4:0] rm,
                        input logic urm, input logic multi, input logic mr,
                        input logic [4:0] rd, input logic br, input logic done);
        exp_t e;
        bit   hazard;
        @(posedge clk);
        #1;
        reset = r; id_rn = rn; id_rm = rm; id_uses_rm = urm; id_multi = multi;
        ex_memread = mr; ex_rd = rd; br_taken = br; mc_done = done;
        e = '0;
        if (r) begin
            e.err = m_err;
            e.cnt = CNT_W'(m_cnt);
            hazard = mr && (rd != 5'd31) && ((rd == rn) || (urm && (rd == rm)));
            if (!m_wait) begin
                if (br) begin
                    e.pc = 1; e.ifid = 1; e.idex = 1; e.flush = 1; e.bub = 1;
                end else if (hazard) begin
                    e.idex = 1; e.bub = 1;
                end else if (multi) begin
                    e.start = 1; e.idex = 1; e.bub = 1;
                    m_wait = 1; m_wc = 0;
                end else begin
                    e.pc = 1; e.ifid = 1; e.idex = 1;
                end
            end else if (done || m_wc == TO - 1) begin
                e.pc = 1; e.ifid = 1; e.idex = 1;
                if (!done) m_err = 1;
                m_wait = 0;
            end else begin
                m_wc++;
            end
            if (!e.pc && m_cnt < CMAX) m_cnt++;
        end else begin
            m_wait = 0; m_wc = 0; m_err = 0; m_cnt = 0;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic multi_op();
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic done_pulse();
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {pc_en, ifid_en, idex_en, idex_bubble, ifid_flush, mc_start, mc_err, stall_cnt};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got pc/ifid/idex/bub/flush/start/err=%b%b%b%b%b%b%b cnt=%0d exp=%b%b%b%b%b%b%b cnt=%0d",
                         cyc, got.pc, got.ifid, got.idex, got.bub, got.flush, got.start, got.err, got.cnt,
                         e.pc, e.ifid, e.idex, e.bub, e.flush, e.start, e.err, e.cnt);
            end
        end
    end

    initial begin
        // Reset for three cycles, then release idle.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Load-use on rn, then a load to the zero register that must not stall.
        step(1, 3, 0, 0, 0, 1, 3, 0, 0);
        idle(1);
        step(1, 31, 0, 0, 0, 1, 31, 0, 0);
        idle(1);
        // Branch taken with a simultaneous rm hazard.
        step(1, 0, 5, 1, 0, 1, 5, 1, 0);
        idle(1);
        // Multicycle op completing after four wait cycles.
        multi_op();
        idle(4);
        done_pulse();
        idle(1);
        // Timeout, then a normal op; the error flag must persist.
        multi_op();
        idle(10);
        multi_op();
        idle(2);
        done_pulse();
        idle(2);
        // Reset dropped mid-wait, between clock edges.
        multi_op();
        idle(2);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Randomized traffic; register numbers drawn from a small set to force matches.
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] rn, rm, rd;
            logic       r;
            int         v;
            v  = int'($urandom_range(0, 7)); rn = (v == 7) ? 5'd31 : 5'(v);
            v  = int'($urandom_range(0, 7)); rm = (v == 7) ? 5'd31 : 5'(v);
            v  = int'($urandom_range(0, 7)); rd = (v == 7) ? 5'd31 : 5'(v);
            r  = ($urandom_range(0, 199) != 0);
            step(r, rn, rm, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), rd, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0));
        end
        idle(1);
        @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
